// File: rtl/pipelined_barrel_rotator_n.sv
// pipelined_barrel_rotator_n: log2(N)-stage rotate/shift pipeline with valid/ready on both sides.
// Stage k moves the word by 2^k when amt[k] is set; a ready chain lets bubbles collapse.
module pipelined_barrel_rotator_n #(
  parameter  int N  = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("pipelined_barrel_rotator_n: N must be a power of two and at least 2");
  end

  // Tap k is the input of stage k; tap AW is the pipeline output.
  logic [AW:0]   w_v;
  logic [N-1:0]  w_data [AW+1];
  logic [AW-1:0] w_amt  [AW];
  logic          w_dir  [AW];
  logic [1:0]    w_mode [AW];
  logic [AW-1:0] w_load;

  assign w_v[0]    = in_valid;
  assign w_data[0] = in_data;
  assign w_amt[0]  = in_amt;
  assign w_dir[0]  = in_dir;
  assign w_mode[0] = in_mode;

  assign in_ready  = w_load[0];
  assign out_valid = w_v[AW];
  assign out_data  = w_data[AW];

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin : p_ready_chain
    logic w_down;
    w_load = '0;
    w_down = out_ready;
    for (int k = AW - 1; k >= 0; k--) begin
      w_down    = !w_v[k+1] || w_down;
      w_load[k] = w_down;
    end
  end

  for (genvar gi = 0; gi < AW; gi++) begin : g_stage
    localparam int S = 1 << gi;

    logic [N-1:0] w_src;
    logic [N-1:0] w_moved;
    logic         w_is_shift;
    logic         w_fill;
    logic         r_v;
    logic [N-1:0] r_data;

    assign w_src      = w_data[gi];
    assign w_is_shift = (w_mode[gi] == 2'b01) || (w_mode[gi] == 2'b10);
    // Sign-filled right moves never change the MSB, so it still holds the original sign.
    assign w_fill     = (w_mode[gi] == 2'b10) && w_src[N-1];

    always_comb begin
      w_moved = w_src;
      if (w_amt[gi][gi]) begin
        if (!w_dir[gi]) begin
          w_moved = w_is_shift ? {w_src[N-S-1:0], {S{1'b0}}}
                               : {w_src[N-S-1:0], w_src[N-1:N-S]};
        end else begin
          w_moved = w_is_shift ? {{S{w_fill}}, w_src[N-1:S]}
                               : {w_src[S-1:0], w_src[N-1:S]};
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v    <= 1'b0;
        r_data <= '0;
      end else if (w_load[gi]) begin
        r_v <= w_v[gi];
        if (w_v[gi]) begin
          r_data <= w_moved;
        end
      end
    end

    assign w_v[gi+1]    = r_v;
    assign w_data[gi+1] = r_data;

    if (gi < AW - 1) begin : g_ctl
      logic [AW-1:0] r_amt;
      logic          r_dir;
      logic [1:0]    r_mode;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_amt  <= '0;
          r_dir  <= 1'b0;
          r_mode <= 2'b00;
        end else if (w_load[gi] && w_v[gi]) begin
          r_amt  <= w_amt[gi];
          r_dir  <= w_dir[gi];
          r_mode <= w_mode[gi];
        end
      end

      assign w_amt[gi+1]  = r_amt;
      assign w_dir[gi+1]  = r_dir;
      assign w_mode[gi+1] = r_mode;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_rotator_n.sv
// Self-checking bench for pipelined_barrel_rotator_n: directed vectors, random streaming with
// back-pressure against a bit-index reference model, mid-stream reset, and N=2 / N=32 builds.
module tb_pipelined_barrel_rotator_n;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [2:0]   in_amt;
  logic         in_dir;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;

  logic         x_valid;
  logic         x_dir;
  logic [1:0]   x_mode;
  logic         x_oready;
  logic         x2_ready;
  logic         x2_ovalid;
  logic [1:0]   x2_data;
  logic [1:0]   x2_odata;
  logic [0:0]   x2_amt;
  logic         x32_ready;
  logic         x32_ovalid;
  logic [31:0]  x32_data;
  logic [31:0]  x32_odata;
  logic [4:0]   x32_amt;

  pipelined_barrel_rotator_n #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_dir(in_dir), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  pipelined_barrel_rotator_n #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_valid), .in_ready(x2_ready), .in_data(x2_data), .in_amt(x2_amt),
    .in_dir(x_dir), .in_mode(x_mode),
    .out_valid(x2_ovalid), .out_ready(x_oready), .out_data(x2_odata)
  );

  pipelined_barrel_rotator_n #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_valid), .in_ready(x32_ready), .in_data(x32_data), .in_amt(x32_amt),
    .in_dir(x_dir), .in_mode(x_mode),
    .out_valid(x32_ovalid), .out_ready(x_oready), .out_data(x32_odata)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_in  = 0;
  logic [7:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: each result bit picks its source bit by index arithmetic.
  function automatic logic [7:0] ref_op(input logic [7:0] a, input int amt,
                                        input logic dir, input logic [1:0] mode);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == 2'b00 || mode == 2'b11)
        res[i] = dir ? a[(i + amt) % N] : a[(i - amt + N) % N];
      else if (!dir)
        res[i] = (i >= amt) ? a[i - amt] : 1'b0;
      else
        res[i] = (i + amt < N) ? a[i + amt] : ((mode == 2'b10) ? a[N-1] : 1'b0);
    end
    return res;
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] a, input int n);
    logic [63:0] t;
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    t = {32'd0, a} & mask;
    t = ((t << 1) | (t >> (n - 1))) & mask;
    return t[31:0];
  endfunction

  task automatic rand_in();
    in_data = 8'($urandom);
    in_amt  = 3'($urandom_range(0, 7));
    in_dir  = 1'($urandom_range(0, 1));
    in_mode = 2'($urandom_range(0, 3));
  endtask

  // One clock of the main DUT: sample at negedge, score handshakes, advance to posedge+1.
  task automatic step();
    logic in_fire;
    logic out_fire;
    @(negedge clk);
    chk("in_ready", in_ready, !(exp_q.size() == 3 && !out_ready));
    if (exp_q.size() == 0) chk("idle_out_valid", out_valid, 0);
    if (hold_pending) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_data);
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
      else chk("out_data", out_data, exp_q.pop_front());
    end
    if (in_fire) begin
      exp_q.push_back(ref_op(in_data, int'(in_amt), in_dir, in_mode));
      n_in++;
    end
    hold_pending = out_valid && !out_ready;
    hold_data    = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [2:0] amt,
                          input logic dir, input logic [1:0] mode, input logic [7:0] expv);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = a;
    in_amt    = amt;
    in_dir    = dir;
    in_mode   = mode;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_data"}, out_data, expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    int lat2;
    int lat32;
    logic [31:0] r;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; in_mode = 2'b00;
    out_ready = 1'b1;
    x_valid = 1'b0; x_dir = 1'b1; x_mode = 2'b00; x_oready = 1'b1;
    x2_data = '0; x2_amt = 1'b1; x32_data = '0; x32_amt = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    directed("rotr3",   8'b1011_0001, 3'd3, 1'b1, 2'b00, 8'b0011_0110);
    directed("rotl3",   8'b1011_0001, 3'd3, 1'b0, 2'b00, 8'b1000_1101);
    directed("lsr3",    8'b1011_0001, 3'd3, 1'b1, 2'b01, 8'b0001_0110);
    directed("asr3",    8'b1011_0001, 3'd3, 1'b1, 2'b10, 8'b1111_0110);
    directed("asl3",    8'b1011_0001, 3'd3, 1'b0, 2'b10, 8'b1000_1000);
    directed("mode11",  8'b1011_0001, 3'd3, 1'b1, 2'b11, 8'b0011_0110);
    directed("lsl7",    8'b1011_0001, 3'd7, 1'b0, 2'b01, 8'b1000_0000);
    for (int m = 0; m < 4; m++)
      directed("amt0", 8'b1011_0001, 3'd0, 1'($urandom_range(0, 1)), 2'(m), 8'b1011_0001);

    for (int t = 0; t < 4; t++) begin
      r        = $urandom;
      x2_data  = r[1:0];
      x32_data = r;
      x_mode   = (t % 2 == 0) ? 2'b00 : 2'b11;
      x_valid  = 1'b1;
      @(negedge clk);
      chk("n2_rdy", x2_ready, 1);
      chk("n32_rdy", x32_ready, 1);
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      lat2 = 0;
      lat32 = 0;
      for (int c = 1; c <= 10; c++) begin
        if (lat2 == 0 && x2_ovalid) begin
          lat2 = c;
          chk("n2_rot", x2_odata, rotl1({30'd0, r[1:0]}, 2));
        end
        if (lat32 == 0 && x32_ovalid) begin
          lat32 = c;
          chk("n32_rot", x32_odata, rotl1(r, 32));
        end
        @(posedge clk);
        #1;
      end
      chk("n2_lat", lat2, 1);
      chk("n32_lat", lat32, 5);
    end

    base = n_in;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rand_in();
      step();
    end
    chk("stream_count", n_in - base, 100);
    drain();

    base = n_in;
    cyc = 0;
    while (n_in - base < 1000 && cyc < 20000) begin
      rand_in();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    chk("bp_count", n_in - base, 1000);
    drain();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_in();
      step();
    end
    chk("inflight", exp_q.size(), 3);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    exp_q.delete();
    hold_pending = 1'b0;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();

    in_valid = 1'b1;
    rand_in();
    step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
